// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the load/store memory arbiter: access subtypes,
// the "no ROB entry" tag and the arbiter FSM encoding.
package mem_arbiter_pkg;

   localparam logic [5:0] INVALID_ROB = 6'b010000;

   localparam logic [2:0] SUB_B  = 3'b000;
   localparam logic [2:0] SUB_H  = 3'b001;
   localparam logic [2:0] SUB_W  = 3'b010;
   localparam logic [2:0] SUB_BU = 3'b100;
   localparam logic [2:0] SUB_HU = 3'b101;

   typedef enum logic [1:0] {
      ARB_IDLE      = 2'd0,
      ARB_ISSUE     = 2'd1,
      ARB_WAIT      = 2'd2,
      ARB_WRITEBACK = 2'd3
   } arb_state_t;

   typedef enum logic {
      GRANT_LOAD  = 1'b0,
      GRANT_STORE = 1'b1
   } grant_t;

   // Byte enables for a store; anything that is not byte/half is a word.
   function automatic logic [3:0] store_mask(input logic [2:0] sub, input logic [1:0] addr_lo);
      case (sub)
         SUB_B:   return 4'b0001 << addr_lo;
         SUB_H:   return addr_lo[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   // Replicate the right-aligned store data into every lane so the mask alone
   // picks the destination bytes.
   function automatic logic [31:0] store_lanes(input logic [2:0] sub, input logic [31:0] data);
      case (sub)
         SUB_B:   return {4{data[7:0]}};
         SUB_H:   return {2{data[15:0]}};
         default: return data;
      endcase
   endfunction

endpackage

// File: rtl/mem_arbiter_load_align.sv
// Extracts the addressed byte/halfword from a read word and extends it.
module load_align
   import mem_arbiter_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  subtype,
   output logic [31:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Lane select followed by sign/zero extension; unknown subtypes pass the word.
   always_comb begin
      byte_sel = 8'h00;
      half_sel = half_sel_f(rdata, addr_lo[1]);
      case (addr_lo)
         2'd0: byte_sel = rdata[7:0];
         2'd1: byte_sel = rdata[15:8];
         2'd2: byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      case (subtype)
         SUB_B:   data = {{24{byte_sel[7]}}, byte_sel};
         SUB_BU:  data = {24'h000000, byte_sel};
         SUB_H:   data = {{16{half_sel[15]}}, half_sel};
         SUB_HU:  data = {16'h0000, half_sel};
         default: data = rdata;
      endcase
   end

   function automatic logic [15:0] half_sel_f(input logic [31:0] w, input logic hi);
      return hi ? w[31:16] : w[15:0];
   endfunction

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the load RS and committed stores onto a single memory port,
// one access in flight, and returns load results on the CDB.
//
// state          | meaning
// ---------------+----------------------------------------------------------
// ARB_IDLE       | grants offered combinationally, request latched on grant
// ARB_ISSUE      | one-cycle mem_en strobe
// ARB_WAIT       | hold until mem_done; load result captured on mem_done
// ARB_WRITEBACK  | one-cycle cdb_valid (unless killed) or st_done pulse
module mem_arbiter
   import mem_arbiter_pkg::arb_state_t;
   import mem_arbiter_pkg::ARB_IDLE;
   import mem_arbiter_pkg::ARB_ISSUE;
   import mem_arbiter_pkg::ARB_WAIT;
   import mem_arbiter_pkg::ARB_WRITEBACK;
   import mem_arbiter_pkg::grant_t;
   import mem_arbiter_pkg::GRANT_LOAD;
   import mem_arbiter_pkg::GRANT_STORE;
   import mem_arbiter_pkg::store_mask;
   import mem_arbiter_pkg::store_lanes;
#(
   parameter logic [5:0] INVALID_ROB = mem_arbiter_pkg::INVALID_ROB
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        flush,
   input  logic        ld_valid,
   output logic        ld_ready,
   input  logic [31:0] ld_addr,
   input  logic [2:0]  ld_subtype,
   input  logic [5:0]  ld_rob,
   input  logic        st_valid,
   output logic        st_ready,
   input  logic [31:0] st_addr,
   input  logic [31:0] st_data,
   input  logic [2:0]  st_subtype,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wmask,
   input  logic        mem_done,
   input  logic [31:0] mem_rdata,
   output logic        cdb_valid,
   output logic [31:0] cdb_data,
   output logic [5:0]  cdb_rob,
   output logic        st_done
);

   arb_state_t  state, state_nx;
   grant_t      last_grant;
   logic        kill;
   logic        req_load;
   logic [31:0] lat_addr;
   logic [31:0] lat_data;
   logic [2:0]  lat_sub;
   logic [5:0]  lat_rob;
   logic [31:0] rd_result;
   logic [31:0] ld_result;
   logic        grant_ld, grant_st;
   logic        in_access;

   load_align u_load_align (
      .rdata   (mem_rdata),
      .addr_lo (lat_addr[1:0]),
      .subtype (lat_sub),
      .data    (ld_result)
   );

   // Round-robin grant in IDLE; a flush hides the load requester for the cycle.
   always_comb begin
      grant_ld = 1'b0;
      grant_st = 1'b0;
      if (state == ARB_IDLE) begin
         if (ld_valid && !flush && (!st_valid || last_grant == GRANT_STORE))
            grant_ld = 1'b1;
         else if (st_valid)
            grant_st = 1'b1;
      end
      ld_ready = grant_ld;
      st_ready = grant_st;
   end

   // Next-state logic.
   always_comb begin
      state_nx = state;
      case (state)
         ARB_IDLE:      if (grant_ld || grant_st) state_nx = ARB_ISSUE;
         ARB_ISSUE:     state_nx = ARB_WAIT;
         ARB_WAIT:      if (mem_done) state_nx = ARB_WRITEBACK;
         ARB_WRITEBACK: state_nx = ARB_IDLE;
         default:       state_nx = ARB_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= ARB_IDLE;
      else        state <= state_nx;
   end

   // Request latch, grant history and load result capture.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         last_grant <= GRANT_STORE;
         req_load   <= 1'b0;
         lat_addr   <= 32'h0;
         lat_data   <= 32'h0;
         lat_sub    <= 3'b000;
         lat_rob    <= 6'h00;
         rd_result  <= 32'h0;
      end else begin
         if (grant_ld) begin
            last_grant <= GRANT_LOAD;
            req_load   <= 1'b1;
            lat_addr   <= ld_addr;
            lat_sub    <= ld_subtype;
            lat_rob    <= ld_rob;
         end else if (grant_st) begin
            last_grant <= GRANT_STORE;
            req_load   <= 1'b0;
            lat_addr   <= st_addr;
            lat_sub    <= st_subtype;
            lat_data   <= st_data;
         end
         if (state == ARB_WAIT && mem_done && req_load)
            rd_result <= ld_result;
      end
   end

   // Kill bit: a flush while a load is outstanding lets the access finish but
   // silences its broadcast. A flush during WRITEBACK is too late to matter.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         kill <= 1'b0;
      else if (grant_ld || grant_st)
         kill <= 1'b0;
      else if ((state == ARB_ISSUE || state == ARB_WAIT) && req_load && flush)
         kill <= 1'b1;
   end

   // Memory port and completion outputs decoded from state and latched request.
   always_comb begin
      in_access = (state == ARB_ISSUE) || (state == ARB_WAIT);
      mem_en    = (state == ARB_ISSUE);
      mem_addr  = {lat_addr[31:2], 2'b00};
      mem_we    = in_access && !req_load;
      mem_wmask = mem_we ? store_mask(lat_sub, lat_addr[1:0]) : 4'b0000;
      mem_wdata = mem_we ? store_lanes(lat_sub, lat_data) : 32'h0;
      cdb_valid = (state == ARB_WRITEBACK) && req_load && !kill;
      cdb_data  = cdb_valid ? rd_result : 32'h0;
      cdb_rob   = cdb_valid ? lat_rob : INVALID_ROB;
      st_done   = (state == ARB_WRITEBACK) && !req_load;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter INVALID_ROB, default 6'b010000, ROB tag meaning "no entry".
REQ-002 SHALL have port clock  in  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port flush  in  1  squash the pending load.
REQ-005 SHALL have port ld_valid  in  1  load request from the load RS.
REQ-006 SHALL have port ld_ready  out  1  load request accepted this cycle.
REQ-007 SHALL have port ld_addr  in  32  load byte address.
REQ-008 SHALL have port ld_subtype  in  3  LB=000, LH=001, LW=010, LBU=100, LHU=101.
REQ-009 SHALL have port ld_rob  in  6  destination ROB tag.
REQ-010 SHALL have port st_valid  in  1  committed store request.
REQ-011 SHALL have port st_ready  out  1  store request accepted this cycle.
REQ-012 SHALL have port st_addr  in  32  store byte address.
REQ-013 SHALL have port st_data  in  32  store data, right-aligned.
REQ-014 SHALL have port st_subtype  in  3  SB=000, SH=001, SW=010.
REQ-015 SHALL have port mem_en  out  1  one-cycle memory access strobe.
REQ-016 SHALL have port mem_we  out  1  1 = write.
REQ-017 SHALL have port mem_addr  out  32  word address: latched address with [1:0] forced to 0.
REQ-018 SHALL have port mem_wdata  out  32  lane-shifted store data.
REQ-019 SHALL have port mem_wmask  out  4  byte enables.
REQ-020 SHALL have port mem_done  in  1  access complete; mem_rdata valid.
REQ-021 SHALL have port mem_rdata  in  32  read word.
REQ-022 SHALL have port cdb_valid  out  1  one-cycle load-result broadcast.
REQ-023 SHALL have port cdb_data  out  32  extended load result.
REQ-024 SHALL have port cdb_rob  out  6  tag of the broadcast; INVALID_ROB when idle.
REQ-025 SHALL have port st_done  out  1  one-cycle store-complete pulse.

Function
REQ-026 SHALL implement FSM IDLE -> ISSUE -> WAIT -> WRITEBACK -> IDLE, one request in flight at a time.
REQ-027 IDLE: ld_ready/st_ready SHALL be combinational grants; a transfer occurs on valid&ready; only one grant per cycle; the FSM moves to ISSUE and latches the request.
REQ-028 Simultaneous valid requests SHALL be granted round-robin (last_grant flag, initially load-first); a single requester is always granted.
REQ-029 ISSUE SHALL assert mem_en for exactly one cycle, then go to WAIT.
REQ-030 WAIT SHALL hold until mem_done=1; mem_done outside WAIT SHALL be ignored; there is no timeout.
REQ-031 WRITEBACK SHALL pulse cdb_valid (load) or st_done (store) for one cycle, then return to IDLE; minimum latency grant-to-pulse is 3 cycles when mem_done arrives in the first WAIT cycle.
REQ-032 Load lane select: LB/LBU use addr[1:0]; LH/LHU use addr[1]; LW uses the whole word. LB/LH sign-extend, LBU/LHU zero-extend.
REQ-033 Store wmask: SB 0001<<addr[1:0]; SH 0011<<(2*addr[1]); SW 1111. Data SHALL be replicated into the selected lane.
REQ-034 Undefined subtypes SHALL be treated as word access.
REQ-035 flush SHALL be ignored for a latched store; stores always complete.
REQ-036 flush on a latched load in ISSUE/WAIT SHALL set a kill bit: the memory access still completes, but cdb_valid is suppressed. flush in IDLE SHALL block ld_ready that cycle.
REQ-037 A flush in the same cycle as the WRITEBACK state SHALL NOT cancel that broadcast.

Reset
REQ-038 Reset low SHALL force IDLE, clear kill and set last_grant=store; all outputs 0 except cdb_rob=INVALID_ROB.
REQ-039 Reset mid-operation SHALL abandon the access without a pulse; a later mem_done SHALL be ignored.

Structure
REQ-040 Shared package SHALL hold subtype encodings, INVALID_ROB and FSM state encoding (shared with loadRS/ROB).
REQ-041 Load extraction and extension SHALL be a combinational sub-module, load_align.
REQ-042 All remaining logic SHALL be a single module.

Verification
REQ-043 LB at addr 0x103, mem_rdata=0x80FF_FF00, rob 5, done after 2 WAIT cycles -> cdb_valid 1 cycle, cdb_data=0xFFFF_FF80, cdb_rob=5, mem_addr=0x100.
REQ-044 SH at addr 0x22, data 0x1234ABCD -> mem_we=1, wmask=1100, wdata[31:16]=0xABCD, then st_done pulse.
REQ-045 ld_valid and st_valid held high for 4 transactions -> grant order load, store, load, store.
REQ-046 LW issued, flush during WAIT, then mem_done -> no cdb_valid, FSM back to IDLE, next load accepted.
REQ-047 Reset asserted in WAIT, then mem_done -> no pulse, outputs at reset values, cdb_rob=0x10.
